// File: rtl/ram_lsu.sv
// ram_lsu: load/store unit sitting directly in front of a single-port,
// synchronous-read RAM. Accepts one word read or write per req/ready
// handshake, registers every RAM-side signal and returns read data with a
// one-cycle rvalid strobe three cycles after the read is accepted.
//
// Optional feature (macro LSU_ZERO_INIT_EN): after reset the LSU sweeps the
// whole RAM writing zeros (2**SZB cycles) before raising init_done/ready.
// With the macro undefined there is no sweep; the LSU is ready one cycle
// after reset.
//
// Parameters:
//   BIT  data word width (default `BIT_DATA), must match the RAM
//   SZB  address width, RAM depth 2**SZB (default `SZB_RAM), must match the RAM
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   req, we, addr,    core request (held by the core until ready)
//   wdata
//   ready             request accepted on any cycle with req && ready
//   rvalid, rdata     read response strobe and data (rdata holds between reads)
//   init_done         high once requests can be accepted
//   ram_we, ram_addr, registered RAM controls
//   ram_d
//   ram_q             RAM read data, valid the cycle after ram_addr is presented

`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef SZB_RAM
`define SZB_RAM 4
`endif

module ram_lsu #(
   parameter int unsigned BIT = `BIT_DATA,
   parameter int unsigned SZB = `SZB_RAM
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           req,
   input  logic           we,
   input  logic [SZB-1:0] addr,
   input  logic [BIT-1:0] wdata,
   output logic           ready,
   output logic           rvalid,
   output logic [BIT-1:0] rdata,
   output logic           init_done,
   output logic           ram_we,
   output logic [SZB-1:0] ram_addr,
   output logic [BIT-1:0] ram_d,
   input  logic [BIT-1:0] ram_q
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
`ifdef LSU_ZERO_INIT_EN
      ,
      INIT    = 2'd3
`endif
   } state_t;

   state_t         state, state_n;
   logic           ready_n;
   logic           rvalid_n;
   logic [BIT-1:0] rdata_n;
   logic           init_done_n;
   logic           ram_we_n;
   logic [SZB-1:0] ram_addr_n;
   logic [BIT-1:0] ram_d_n;

`ifdef LSU_ZERO_INIT_EN
   logic [SZB-1:0] cnt, cnt_n;
`endif

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
`ifdef LSU_ZERO_INIT_EN
         state     <= INIT;
         cnt       <= '0;
`else
         state     <= IDLE;
`endif
         ready     <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         init_done <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_d     <= '0;
      end else begin
         state     <= state_n;
`ifdef LSU_ZERO_INIT_EN
         cnt       <= cnt_n;
`endif
         ready     <= ready_n;
         rvalid    <= rvalid_n;
         rdata     <= rdata_n;
         init_done <= init_done_n;
         ram_we    <= ram_we_n;
         ram_addr  <= ram_addr_n;
         ram_d     <= ram_d_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      ready_n     = 1'b0;
      rvalid_n    = 1'b0;
      rdata_n     = rdata;
      init_done_n = init_done;
      ram_we_n    = 1'b0;
      ram_addr_n  = ram_addr;
      ram_d_n     = ram_d;
`ifdef LSU_ZERO_INIT_EN
      cnt_n       = cnt;
`endif

      case (state)
         IDLE: begin
            ready_n     = 1'b1;
            init_done_n = 1'b1;
            // ready is still low on the first cycle after reset, so a
            // request is only taken once ready has actually been shown
            if (req && ready) begin
               ram_addr_n = addr;
               if (we) begin
                  ram_we_n = 1'b1;
                  ram_d_n  = wdata;
               end else begin
                  state_n = RD_ADDR;
                  ready_n = 1'b0;
               end
            end
         end

         // RAM samples ram_addr at the end of this cycle
         RD_ADDR: state_n = RD_DATA;

         // ram_q now holds the addressed word
         RD_DATA: begin
            rdata_n  = ram_q;
            rvalid_n = 1'b1;
            ready_n  = 1'b1;
            state_n  = IDLE;
         end

`ifdef LSU_ZERO_INIT_EN
         INIT: begin
            // Last sweep write is on the RAM port: stop and open for requests
            if (ram_we && (ram_addr == '1)) begin
               state_n     = IDLE;
               ready_n     = 1'b1;
               init_done_n = 1'b1;
            end else begin
               ram_we_n   = 1'b1;
               ram_addr_n = cnt;
               ram_d_n    = '0;
               cnt_n      = cnt + SZB'(1);
            end
         end
`endif

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu (BIT=8, SZB=4). A behavioural RAM sits on
// the RAM port; a reference memory updated at request acceptance supplies the
// expected read data. Expected RAM writes and read responses are queued by the
// driver and popped by an independent monitor on ram_we / rvalid.

module tb_ram_lsu;

   localparam int unsigned BIT = 8;
   localparam int unsigned SZB = 4;
   localparam int unsigned DEPTH = 1 << SZB;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           req   = 1'b0;
   logic           we    = 1'b0;
   logic [SZB-1:0] addr  = '0;
   logic [BIT-1:0] wdata = '0;
   logic           ready;
   logic           rvalid;
   logic [BIT-1:0] rdata;
   logic           init_done;
   logic           ram_we;
   logic [SZB-1:0] ram_addr;
   logic [BIT-1:0] ram_d;
   logic [BIT-1:0] ram_q = '0;

   ram_lsu #(.BIT(BIT), .SZB(SZB)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata),
      .init_done(init_done), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_d(ram_d), .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous-read RAM model
   logic [BIT-1:0] mem [DEPTH] = '{default: 8'h00};
   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
   end

   typedef struct {
      int             cyc;   // cycle in which the item must be visible
      logic [SZB-1:0] a;
      logic [BIT-1:0] d;
   } exp_t;

   exp_t wr_q[$];
   exp_t rd_q[$];
   logic [BIT-1:0] ref_mem [DEPTH] = '{default: 8'h00};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations when the DUT presents a RAM write or a read response
   logic [BIT-1:0] last_rdata = '0;
   logic [BIT-1:0] last_d     = '0;
   exp_t           e;
   always @(negedge clock) begin
      if (reset) begin
         last_rdata = '0;
         last_d     = '0;
      end else begin
         if (ram_we) begin
            chk("ram_we_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               chk("wr_cycle", 32'(cyc), 32'(e.cyc));
               chk("wr_addr", 32'(ram_addr), 32'(e.a));
               chk("wr_data", 32'(ram_d), 32'(e.d));
               last_d = e.d;
            end
         end else begin
            chk("ram_d_hold", 32'(ram_d), 32'(last_d));
         end
         if (rvalid) begin
            chk("rvalid_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               chk("rd_cycle", 32'(cyc), 32'(e.cyc));
               chk("rd_data", 32'(rdata), 32'(e.d));
               last_rdata = e.d;
            end
         end else begin
            chk("rdata_hold", 32'(rdata), 32'(last_rdata));
         end
      end
   end

   // Called #1 after a rising edge. Holds reset for n edges, checks the reset
   // outputs, releases and checks when init_done rises.
   task automatic do_reset(input int n);
      int rel;
      reset = 1'b1;
      rd_q.delete();
      wr_q.delete();
      repeat (n - 1) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_d", 32'(ram_d), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      rel = cyc;
`ifdef LSU_ZERO_INIT_EN
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_mem[i] = '0;
         wr_q.push_back('{rel + 1 + i, SZB'(i), '0});
      end
`endif
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (init_done === 1'b1) break;
      end
`ifdef LSU_ZERO_INIT_EN
      chk("init_done_cycle", 32'(cyc), 32'(rel + 1 + int'(DEPTH)));
`else
      chk("init_done_cycle", 32'(cyc), 32'(rel + 1));
`endif
      chk("ready_at_init_done", 32'(ready), 32'd1);
      @(posedge clock);
      #1;
   endtask

   // Called #1 after a rising edge; holds the request until accepted.
   // Returns #1 after the accepting edge with req dropped.
   task automatic issue(input logic w, input logic [SZB-1:0] a,
                        input logic [BIT-1:0] d, output int acc);
      req = 1'b1; we = w; addr = a; wdata = d;
      acc = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (ready === 1'b1) acc = cyc;
         @(posedge clock);
         #1;
         if (acc >= 0) break;
      end
      req = 1'b0;
      chk("accept_in_time", 32'(acc >= 0), 32'd1);
      if (acc >= 0) begin
         if (w) begin
            ref_mem[a] = d;
            wr_q.push_back('{acc + 1, a, d});
         end else begin
            rd_q.push_back('{acc + 3, a, ref_mem[a]});
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      int acc, prev;
      logic [BIT-1:0] d;

      do_reset(2);

      // Single write then read of the same word
      issue(1'b1, 4'd3, 8'hA5, acc);
      issue(1'b0, 4'd3, 8'h00, acc);
      idle(5);

      // 16 back-to-back writes, then 16 reads held through the busy states
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         issue(1'b1, SZB'(i), d, acc);
         if (i > 0) chk("wr_back_to_back", 32'(acc), 32'(prev + 1));
         prev = acc;
      end
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, SZB'(i), 8'h00, acc);
         if (i > 0) chk("rd_spacing", 32'(acc), 32'(prev + 3));
         prev = acc;
      end
      idle(5);

      // Read accepted while the write to the same word is on the RAM port
      issue(1'b1, 4'd7, 8'h3C, prev);
      issue(1'b0, 4'd7, 8'h00, acc);
      chk("raw_accept_cycle", 32'(acc), 32'(prev + 1));
      idle(4);

      // Random mix
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom_range(0, 1)), SZB'($urandom_range(0, 15)), 8'($urandom), acc);
         idle(int'($urandom_range(0, 2)));
      end
      idle(5);

      // Reset while the read is in RD_DATA: response must be dropped
      issue(1'b1, 4'd5, 8'h5A, acc);
      issue(1'b0, 4'd5, 8'h00, acc);
      idle(1);
      do_reset(2);
      issue(1'b1, 4'd9, 8'hC3, acc);
      issue(1'b0, 4'd9, 8'h00, acc);
      issue(1'b0, 4'd5, 8'h00, acc);
      idle(10);

      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
